fetch_controller: RTL and testbench

Sequencer for the fetch stage. Each cycle it generates the 2-bit PC-source select and the PC-write enable consumed by the PC/instruction-memory fetch datapath. It also drives the IF/ID write/flush and ID/EX flush controls. It owns a small return-address stack (RAS) that supplies the return address for RET. It sits between the hazard unit, the ID/EX control-transfer decode and the fetch datapath, and handles multi-cycle instruction-memory responses.

---
 rtl/fetch_controller_pkg.sv | 27 ++
 rtl/fetch_controller_return_address_stack.sv | 70 +++++++
 rtl/fetch_controller.sv | 157 +++++++++++++++
 tb/tb_fetch_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_controller_pkg
// Purpose  : Shared encodings for the fetch stage: PC-source selects, the
//            fetch sequencer state encoding and the default word size.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package fetch_controller_pkg;

   // Default width of PC and return addresses
   localparam int WordSize = 16;

   // PC-source selects, shared with the fetch datapath mux
   localparam logic [1:0] PCSRC_SEQ = 2'b00;  // PC+1
   localparam logic [1:0] PCSRC_BR  = 2'b01;  // I-type / branch target
   localparam logic [1:0] PCSRC_JMP = 2'b10;  // J-type target (jump/call)
   localparam logic [1:0] PCSRC_RET = 2'b11;  // return address from RAS

   // Fetch sequencer states
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_controller_return_address_stack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : return_address_stack
// Purpose  : Circular return-address stack. A push when full overwrites the
//            oldest entry; a pop when empty leaves the stack untouched. Both
//            cases raise a one-cycle registered error pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module return_address_stack
   import fetch_controller_pkg::*;
#(
   parameter int WordSize  = fetch_controller_pkg::WordSize,
   parameter int RAS_DEPTH = 4
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic                pop,
   input  logic [WordSize-1:0] push_data,
   output logic [WordSize-1:0] top,
   output logic                empty,
   output logic                error
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [WordSize-1:0] entries [RAS_DEPTH];
   logic [PTR_W-1:0]    ptr;        // next free slot; top lives at ptr-1
   logic [CNT_W-1:0]    count;
   logic [PTR_W-1:0]    top_index;
   logic                full;

   assign full      = (count == CNT_W'(RAS_DEPTH));
   assign empty     = (count == '0);
   assign top_index = ptr - PTR_W'(1);   // wraps because depth is a power of 2
   assign top       = empty ? '0 : entries[top_index];

   // Stack storage, pointer, occupancy and error pulse; pop wins over push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
         error <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         error <= 1'b0;
         if (pop) begin
            if (empty) begin
               error <= 1'b1;
            end else begin
               ptr   <= ptr - PTR_W'(1);
               count <= count - CNT_W'(1);
            end
         end else if (push) begin
            entries[ptr] <= push_data;
            ptr          <= ptr + PTR_W'(1);
            if (full) begin
               error <= 1'b1;             // oldest entry lost
            end else begin
               count <= count + CNT_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_controller
// Purpose  : Fetch-stage sequencer. Picks the PC source, gates PC and IF/ID
//            updates, flushes IF/ID and ID/EX on redirects and stalls, waits
//            out slow instruction-memory responses and owns the RAS.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int WordSize  = fetch_controller_pkg::WordSize,
   parameter int RAS_DEPTH = 4,
   parameter int MAX_WAIT  = 15
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic                jump,
   input  logic                call,
   input  logic                ret,
   input  logic [WordSize-1:0] call_return_pc,
   input  logic                imem_ready,
   output logic [1:0]          pc_src,
   output logic                pc_write,
   output logic                imem_abort,
   output logic                if_id_write,
   output logic                if_id_flush,
   output logic                id_ex_flush,
   output logic [WordSize-1:0] return_address,
   output logic                ras_empty,
   output logic                ras_error,
   output logic                imem_timeout
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   fetch_state_e      state;
   fetch_state_e      next_state;
   logic [WAIT_W-1:0] wait_count;
   logic [WAIT_W-1:0] next_wait_count;
   logic [WAIT_W-1:0] wait_count_inc;
   logic              redirect;
   logic              ras_push;
   logic              ras_pop;

   // Saturating increment of the outstanding-access counter
   assign wait_count_inc = (wait_count == WAIT_W'(MAX_WAIT)) ? wait_count
                                                              : wait_count + WAIT_W'(1);

   // State, wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_BOOT;
         wait_count   <= '0;
         imem_timeout <= 1'b0;
      end else begin
         state      <= next_state;
         wait_count <= next_wait_count;
         if (next_wait_count == WAIT_W'(MAX_WAIT)) begin
            imem_timeout <= 1'b1;
         end
      end
   end

   // Redirect priority, stall handling and imem wait sequencing
   always_comb begin
      next_state      = state;
      next_wait_count = wait_count;
      pc_src          = PCSRC_SEQ;
      pc_write        = 1'b0;
      imem_abort      = 1'b0;
      if_id_write     = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      ras_push        = 1'b0;
      ras_pop         = 1'b0;
      redirect        = 1'b0;

      case (state)
         ST_BOOT: begin
            // Hold the pipeline empty for one cycle while PC/imem settle
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            next_wait_count = '0;
            next_state      = ST_RUN;
         end
         default: begin
            if (branch_taken) begin
               // Oldest instruction wins; younger ID control transfers are squashed
               pc_src      = PCSRC_BR;
               pc_write    = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               redirect    = 1'b1;
            end else if (stall) begin
               // ID instruction holds, so its jump/call/ret waits until release
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
               if (state == ST_WAIT && !imem_ready) begin
                  next_wait_count = wait_count_inc;
               end
            end else if (ret) begin
               // ret beats a simultaneous (illegal) call: pop only
               pc_src      = PCSRC_RET;
               pc_write    = 1'b1;
               if_id_flush = 1'b1;
               ras_pop     = 1'b1;
               redirect    = 1'b1;
            end else if (call) begin
               pc_src      = PCSRC_JMP;
               pc_write    = 1'b1;
               if_id_flush = 1'b1;
               ras_push    = 1'b1;
               redirect    = 1'b1;
            end else if (jump) begin
               pc_src      = PCSRC_JMP;
               pc_write    = 1'b1;
               if_id_flush = 1'b1;
               redirect    = 1'b1;
            end else if (imem_ready) begin
               pc_write        = 1'b1;
               next_wait_count = '0;
               next_state      = ST_RUN;
            end else begin
               // No instruction yet: bubble IF/ID and keep the PC
               if_id_flush     = 1'b1;
               next_wait_count = wait_count_inc;
               next_state      = ST_WAIT;
            end

            if (redirect) begin
               imem_abort      = (state == ST_WAIT);
               next_wait_count = '0;
               next_state      = ST_RUN;
            end
         end
      endcase
   end

   return_address_stack #(
      .WordSize  (WordSize),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (call_return_pc),
      .top       (return_address),
      .empty     (ras_empty),
      .error     (ras_error)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_fetch_controller
// Purpose  : Directed-vector bench for fetch_controller (RAS_DEPTH=4,
//            MAX_WAIT=2) with hand-computed expected values.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall, branch_taken, jump, call, ret, imem_ready;
   logic [15:0] call_return_pc;
   logic [1:0]  pc_src;
   logic        pc_write, imem_abort, if_id_write, if_id_flush, id_ex_flush;
   logic [15:0] return_address;
   logic        ras_empty, ras_error, imem_timeout;

   int vectors     = 0;
   int miscompares = 0;

   fetch_controller #(
      .WordSize  (16),
      .RAS_DEPTH (4),
      .MAX_WAIT  (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .jump           (jump),
      .call           (call),
      .ret            (ret),
      .call_return_pc (call_return_pc),
      .imem_ready     (imem_ready),
      .pc_src         (pc_src),
      .pc_write       (pc_write),
      .imem_abort     (imem_abort),
      .if_id_write    (if_id_write),
      .if_id_flush    (if_id_flush),
      .id_ex_flush    (id_ex_flush),
      .return_address (return_address),
      .ras_empty      (ras_empty),
      .ras_error      (ras_error),
      .imem_timeout   (imem_timeout)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Move to just after the next rising edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Apply inputs for the current cycle and let combinational outputs settle
   task automatic drive(input logic b, input logic r, input logic c, input logic j,
                        input logic s, input logic rdy, input logic [15:0] crp);
      branch_taken   = b;
      ret            = r;
      call           = c;
      jump           = j;
      stall          = s;
      imem_ready     = rdy;
      call_return_pc = crp;
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      next_cycle();
      next_cycle();

      // Reset values
      check_value("rst_pc_src", 32'(pc_src), 32'd0);
      check_value("rst_pc_write", 32'(pc_write), 32'd0);
      check_value("rst_if_id_write", 32'(if_id_write), 32'd1);
      check_value("rst_if_id_flush", 32'(if_id_flush), 32'd1);
      check_value("rst_id_ex_flush", 32'(id_ex_flush), 32'd1);
      check_value("rst_abort", 32'(imem_abort), 32'd0);
      check_value("rst_ret_addr", 32'(return_address), 32'd0);
      check_value("rst_ras_empty", 32'(ras_empty), 32'd1);
      check_value("rst_ras_error", 32'(ras_error), 32'd0);
      check_value("rst_timeout", 32'(imem_timeout), 32'd0);

      // Release: first cycle is BOOT, then sequential fetch
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("boot_pc_write", 32'(pc_write), 32'd0);
      check_value("boot_if_id_flush", 32'(if_id_flush), 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("run1_pc_src", 32'(pc_src), 32'd0);
      check_value("run1_pc_write", 32'(pc_write), 32'd1);
      check_value("run1_if_id_flush", 32'(if_id_flush), 32'd0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("run2_pc_write", 32'(pc_write), 32'd1);

      // call 0x0024, ret three cycles later
      next_cycle();
      drive(0, 0, 1, 0, 0, 1, 16'h0024);
      check_value("call_pc_src", 32'(pc_src), 32'd2);
      check_value("call_if_id_flush", 32'(if_id_flush), 32'd1);
      check_value("call_pc_write", 32'(pc_write), 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("call_ras_empty", 32'(ras_empty), 32'd0);
      check_value("call_top", 32'(return_address), 32'h24);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      next_cycle();
      drive(0, 1, 0, 0, 0, 1, 16'h0);
      check_value("ret_pc_src", 32'(pc_src), 32'd3);
      check_value("ret_addr", 32'(return_address), 32'h24);
      check_value("ret_if_id_flush", 32'(if_id_flush), 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("ret_ras_empty", 32'(ras_empty), 32'd1);
      check_value("ret_ras_error", 32'(ras_error), 32'd0);

      // branch_taken squashes a same-cycle call
      next_cycle();
      drive(1, 0, 1, 0, 0, 1, 16'h0077);
      check_value("br_pc_src", 32'(pc_src), 32'd1);
      check_value("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
      check_value("br_if_id_flush", 32'(if_id_flush), 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("br_no_push", 32'(ras_empty), 32'd1);

      // imem not ready for three cycles, then ready
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         drive(0, 0, 0, 0, 0, 0, 16'h0);
         check_value($sformatf("wait%0d_pc_write", i), 32'(pc_write), 32'd0);
         check_value($sformatf("wait%0d_if_id_flush", i), 32'(if_id_flush), 32'd1);
         check_value($sformatf("wait%0d_abort", i), 32'(imem_abort), 32'd0);
         if (i == 0) check_value("wait0_timeout", 32'(imem_timeout), 32'd0);
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("ready_pc_write", 32'(pc_write), 32'd1);
      check_value("ready_if_id_flush", 32'(if_id_flush), 32'd0);
      check_value("timeout_set", 32'(imem_timeout), 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("timeout_sticky", 32'(imem_timeout), 32'd1);

      // Five calls into a four-deep RAS
      for (int i = 0; i < 5; i++) begin
         if (i > 0) next_cycle();
         drive(0, 0, 1, 0, 0, 1, 16'(16'h10 + i));
         check_value($sformatf("push%0d_pc_src", i), 32'(pc_src), 32'd2);
         check_value($sformatf("push%0d_ras_error", i), 32'(ras_error), 32'd0);
      end
      // Five rets: 0x14, 0x13, 0x12, 0x11, then underflow with 0
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         drive(0, 1, 0, 0, 0, 1, 16'h0);
         check_value($sformatf("pop%0d_pc_src", i), 32'(pc_src), 32'd3);
         check_value($sformatf("pop%0d_addr", i), 32'(return_address),
                     (i < 4) ? 32'(32'h14 - i) : 32'd0);
         check_value($sformatf("pop%0d_ras_error", i), 32'(ras_error), (i == 0) ? 32'd1 : 32'd0);
      end
      check_value("pop4_ras_empty", 32'(ras_empty), 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("underflow_error", 32'(ras_error), 32'd1);
      check_value("underflow_empty", 32'(ras_empty), 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("error_one_cycle", 32'(ras_error), 32'd0);

      // stall with a pending jump for two cycles, then release
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         drive(0, 0, 0, 1, 1, 1, 16'h0);
         check_value($sformatf("stall%0d_pc_write", i), 32'(pc_write), 32'd0);
         check_value($sformatf("stall%0d_if_id_write", i), 32'(if_id_write), 32'd0);
         check_value($sformatf("stall%0d_id_ex_flush", i), 32'(id_ex_flush), 32'd1);
      end
      next_cycle();
      drive(0, 0, 0, 1, 0, 1, 16'h0);
      check_value("unstall_pc_src", 32'(pc_src), 32'd2);
      check_value("unstall_pc_write", 32'(pc_write), 32'd1);
      check_value("unstall_abort", 32'(imem_abort), 32'd0);

      // jump while waiting on imem aborts the access
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 16'h0);
      next_cycle();
      drive(0, 0, 0, 1, 0, 0, 16'h0);
      check_value("wjump_abort", 32'(imem_abort), 32'd1);
      check_value("wjump_pc_src", 32'(pc_src), 32'd2);
      check_value("wjump_pc_write", 32'(pc_write), 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 16'h0);
      check_value("wjump_run_pc_write", 32'(pc_write), 32'd1);
      check_value("wjump_run_abort", 32'(imem_abort), 32'd0);

      // Reset asserted mid-WAIT with a populated RAS
      next_cycle();
      drive(0, 0, 1, 0, 0, 1, 16'h0055);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 16'h0);
      check_value("pre_rst_top", 32'(return_address), 32'h55);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 16'h0);
      rst_n = 1'b0;
      #1;
      check_value("midrst_pc_write", 32'(pc_write), 32'd0);
      check_value("midrst_if_id_flush", 32'(if_id_flush), 32'd1);
      check_value("midrst_ras_empty", 32'(ras_empty), 32'd1);
      check_value("midrst_ret_addr", 32'(return_address), 32'd0);
      check_value("midrst_timeout", 32'(imem_timeout), 32'd0);
      next_cycle();
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
